snap_rx: RTL and testbench
==========================

# snap_rx

Snapshot receiver: watches an 8-bit registered status bus (such as a counter-capture output), detects each value change while enabled, and queues the new values in a small FIFO. The FIFO drains over a valid/ready interface. It sits on the consuming end of capture-style producers and turns a level-held bus into a stream of discrete change events, with a saturating counter for events lost to overflow.

## Interface
- WIDTH, 8: data width of the monitored bus and of the output stream.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- CLK  input  1  clock; all state updates on posedge.
- RSTN  input  1  reset, asynchronous, active-low.
- EN  input  1  change detection enable; sampled on posedge.
- DIN  input  WIDTH  monitored bus; sampled on posedge.
- OUT_DATA  output  WIDTH  FIFO head entry; 0 when empty after reset.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_READY  input  1  consumer accepts head when OUT_VALID=1.
- FULL  output  1  FIFO holds DEPTH entries.
- EMPTY  output  1  FIFO holds 0 entries.
- DROP_CNT  output  8  pushes lost while full; saturates at 255.

## Operation
- Shadow register d_q <= DIN on every posedge, regardless of EN. d_q resets to 0.
- Push condition at an edge: EN=1 and DIN != d_q. Pushed value is DIN. Changes that occur while EN=0 are absorbed into d_q and never reported.
- Because d_q resets to 0, the first non-zero DIN after reset with EN=1 is reported.
- Pop condition at an edge: OUT_VALID=1 and OUT_READY=1. The head entry leaves the FIFO.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - EMPTY is asserted when the pointers are fully equal.
  - FULL is asserted when the MSBs differ and the remaining bits are equal.
- Push while full with no pop: the value is dropped, the FIFO is unchanged, and DROP_CNT increments unless it is already 255.
- Push and pop at the same edge: both take effect, including when full (occupancy unchanged, no drop) and when occupancy is 1.
- Push while empty: the entry is written and appears at OUT_DATA/OUT_VALID after that edge. There is no combinational bypass.
- Pop while empty is ignored; OUT_READY is a don't-care when OUT_VALID=0.
- OUT_DATA holds stable while OUT_VALID=1 and no pop occurs.
- Reset values: d_q=0, pointers=0, storage=0, OUT_DATA=0, OUT_VALID=0, FULL=0, EMPTY=1, DROP_CNT=0.
- Reset asserted mid-operation discards all queued entries immediately (asynchronously) and clears DROP_CNT.

## Timing
- DIN change to OUT_VALID: 1 edge. The change is sampled at edge k and OUT_VALID is high after edge k when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained.
- OUT_VALID, FULL and EMPTY are registered or derived only from registered pointers; no input-to-output combinational path.
- OUT_DATA is a mux of registered storage indexed by the read pointer.
- DROP_CNT updates at the same edge as the dropped push.
- Back-to-back DIN changes on consecutive edges each produce one push.

## Structure
- Shared package snap_rx_pkg holds:
  - constant DROP_CNT_W = 8 and DROP_CNT_MAX = 255;
  - default WIDTH/DEPTH constants;
  - function clog2 for pointer width.
- Sub-module snap_fifo(WIDTH, DEPTH) contains storage, pointers, FULL/EMPTY, and push/pop arbitration, with a drop output strobe.
- Top level snap_rx contains d_q, change detection, and the DROP_CNT saturating counter.

## Test plan
- Reset, EN=1, DIN=0 for 5 cycles -> no push; EMPTY=1, OUT_VALID=0, OUT_DATA=0.
- OUT_READY=1, DIN sequence 0x00, 0x05, 0x05, 0x81 -> exactly two transfers, 0x05 then 0x81, each with OUT_VALID high 1 edge after the DIN change.
- EN=0 while DIN goes 0x10 then 0x20; then EN=1 with DIN held at 0x20 -> no push. DIN->0x21 -> single transfer 0x21.
- OUT_READY=0, six distinct DIN values 1..6 -> FULL=1 after the 4th, DROP_CNT=2. Then OUT_READY=1 -> OUT_DATA 1, 2, 3, 4, after which EMPTY=1.
- FULL with OUT_READY=1 and a DIN change at the same edge -> no drop, DROP_CNT unchanged, FULL stays 1, head advances.
- 300 pushes while full and stalled -> DROP_CNT=255, holds. RSTN pulsed low mid-stream -> all outputs return to reset values within the reset assertion.

Source files
------------

// File: rtl/snap_rx_pkg.sv
// Shared constants and helpers for the snapshot receiver slice.
// Holds the drop-counter geometry, default bus/FIFO sizes and the pointer-width helper.
package snap_rx_pkg;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/snap_fifo.sv
// Small register FIFO with simultaneous push/pop, full-bypass on pop and a drop strobe.
// Storage is register-based because every entry must clear on reset.
module snap_fifo
  import snap_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = ~empty;

  // A pop frees the slot in the same edge, so a push while full still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          mem[gi] <= '0;
        end else if (do_push && (wr_ptr[AW-1:0] == AW'(gi))) begin
          mem[gi] <= push_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/snap_rx.sv
// Snapshot receiver: turns each enabled change of a level-held bus into a queued event,
// counting (with saturation) the events lost while the queue is full.
module snap_rx
  import snap_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  EN,
  input  logic [WIDTH-1:0]      DIN,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  logic [WIDTH-1:0]      d_q;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  change;
  logic                  drop;

  // The shadow tracks DIN even when disabled, so changes seen while EN=0 are absorbed.
  assign change = EN && (DIN != d_q);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      d_q      <= '0;
      drop_cnt <= '0;
    end else begin
      d_q <= DIN;
      if (drop && (drop_cnt != DROP_CNT_MAX)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  snap_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .push     (change),
    .push_data(DIN),
    .pop      (OUT_READY),
    .rd_data  (OUT_DATA),
    .valid    (OUT_VALID),
    .full     (FULL),
    .empty    (EMPTY),
    .drop     (drop)
  );

  assign DROP_CNT = drop_cnt;

endmodule

// File: tb/tb_snap_rx.sv
// Self-checking bench for snap_rx: directed scenarios plus random traffic against a queue model.
module tb_snap_rx;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RSTN;
  logic       EN;
  logic [7:0] DIN;
  logic [7:0] OUT_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic       FULL;
  logic       EMPTY;
  logic [7:0] DROP_CNT;

  int total = 0;
  int bad   = 0;

  // Reference model: event queue, last sampled bus value, drop count.
  logic [7:0] q[$];
  logic [7:0] shadow;
  int         drops;
  bit         fresh;
  logic [7:0] xfers[$];

  snap_rx dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .EN       (EN),
    .DIN      (DIN),
    .OUT_DATA (OUT_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .DROP_CNT (DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shadow = 8'h00;
    drops  = 0;
    fresh  = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, OUT_VALID, q.size() != 0);
    chk({tag, ".empty"}, EMPTY, q.size() == 0);
    chk({tag, ".full"}, FULL, q.size() == DEPTH);
    chk({tag, ".drop"}, DROP_CNT, drops);
    if (q.size() != 0) chk({tag, ".data"}, OUT_DATA, q[0]);
    else if (fresh)    chk({tag, ".data0"}, OUT_DATA, 0);
  endtask

  // One clock: apply inputs, record any DUT transfer, advance the model, check after the edge.
  task automatic cyc(input logic en, input logic [7:0] din, input logic rdy, input string tag);
    bit         pop;
    bit         push;
    logic [7:0] pv;
    EN = en;
    DIN = din;
    OUT_READY = rdy;
    #1;
    if (OUT_VALID && OUT_READY) begin
      xfers.push_back(OUT_DATA);
      $display("xfer data=%02h drop_cnt=%0d", OUT_DATA, DROP_CNT);
    end
    @(posedge CLK);
    pop  = rdy && (q.size() != 0);
    push = en && (din != shadow);
    if (pop) pv = q.pop_front();
    if (push) begin
      if (q.size() < DEPTH) begin
        q.push_back(din);
        fresh = 1'b0;
      end else if (drops < 255) begin
        drops++;
      end
    end
    shadow = din;
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #2;
    chk("rst.valid", OUT_VALID, 0);
    chk("rst.empty", EMPTY, 1);
    chk("rst.full", FULL, 0);
    chk("rst.drop", DROP_CNT, 0);
    chk("rst.data", OUT_DATA, 0);
    @(posedge CLK);
    #1;
    RSTN = 1'b1;
    model_reset();
  endtask

  initial begin
    RSTN = 1'b0;
    EN = 1'b0;
    DIN = 8'h00;
    OUT_READY = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Idle with EN=1 and DIN=0: nothing reported.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 1'b1, "idle");
    chk("idle.nxfer", xfers.size(), 0);

    // Two real changes among repeats, each visible one edge later.
    xfers.delete();
    cyc(1'b1, 8'h00, 1'b1, "seq");
    cyc(1'b1, 8'h05, 1'b1, "seq");
    chk("seq.lat1", OUT_VALID, 1);
    cyc(1'b1, 8'h05, 1'b1, "seq");
    cyc(1'b1, 8'h81, 1'b1, "seq");
    chk("seq.lat2", OUT_VALID, 1);
    chk("seq.lat2d", OUT_DATA, 8'h81);
    cyc(1'b1, 8'h81, 1'b1, "seq");
    cyc(1'b1, 8'h81, 1'b1, "seq");
    chk("seq.nxfer", xfers.size(), 2);
    if (xfers.size() == 2) begin
      chk("seq.x0", xfers[0], 8'h05);
      chk("seq.x1", xfers[1], 8'h81);
    end

    // Changes while disabled are absorbed.
    xfers.delete();
    cyc(1'b0, 8'h10, 1'b1, "dis");
    cyc(1'b0, 8'h20, 1'b1, "dis");
    cyc(1'b1, 8'h20, 1'b1, "dis");
    cyc(1'b1, 8'h20, 1'b1, "dis");
    chk("dis.novalid", OUT_VALID, 0);
    cyc(1'b1, 8'h21, 1'b1, "dis");
    cyc(1'b1, 8'h21, 1'b1, "dis");
    cyc(1'b1, 8'h21, 1'b1, "dis");
    chk("dis.nxfer", xfers.size(), 1);
    if (xfers.size() == 1) chk("dis.x0", xfers[0], 8'h21);

    // Overflow: six values into four slots while stalled.
    xfers.delete();
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 8'(i), 1'b0, "ovf");
      if (i == 4) chk("ovf.full4", FULL, 1);
    end
    chk("ovf.drop2", DROP_CNT, 2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h06, 1'b1, "drain");
    chk("drain.empty", EMPTY, 1);
    chk("drain.nxfer", xfers.size(), 4);
    for (int i = 0; i < xfers.size() && i < 4; i++) chk("drain.x", xfers[i], i + 1);

    // Full with a simultaneous push and pop: no drop, head advances.
    for (int i = 7; i <= 10; i++) cyc(1'b1, 8'(i), 1'b0, "fpp");
    chk("fpp.full", FULL, 1);
    cyc(1'b1, 8'd11, 1'b1, "fpp");
    chk("fpp.drop", DROP_CNT, 2);
    chk("fpp.fullkeep", FULL, 1);
    chk("fpp.head", OUT_DATA, 8'd8);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'd11, 1'b1, "fpp");

    // Drop counter saturation, then asynchronous reset mid-stream.
    for (int i = 0; i < 304; i++) cyc(1'b1, (i % 2 == 0) ? 8'h55 : 8'hAA, 1'b0, "sat");
    chk("sat.255", DROP_CNT, 255);
    cyc(1'b1, 8'h33, 1'b0, "sat");
    chk("sat.hold", DROP_CNT, 255);
    do_reset();
    cyc(1'b1, 8'h00, 1'b0, "post");

    // Random traffic with a small value range so repeats occur.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
